// File: rtl/jtframe_mister_pkg.sv
// Shared constants for the MiSTer HPS download front end: menu indices,
// core-mode reset value and the download classification helper.
package jtframe_mister_pkg;

  localparam int ADDR_W = 27;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_MOD   = 8'd1;
  localparam logic [7:0] IDX_NVRAM = 8'd2;
  localparam logic [7:0] IDX_DIPSW = 8'd254;

  localparam logic [6:0] CORE_MOD_RST = 7'h01;

  typedef enum logic [2:0] {
    DL_NONE,
    DL_ROM,
    DL_MOD,
    DL_NVRAM,
    DL_DIPSW
  } dl_kind_e;

  function automatic dl_kind_e dl_kind(input logic [7:0] idx);
    case (idx)
      IDX_ROM:   return DL_ROM;
      IDX_MOD:   return DL_MOD;
      IDX_NVRAM: return DL_NVRAM;
      IDX_DIPSW: return DL_DIPSW;
      default:   return DL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/jtframe_mister_dlbuf_if.sv
// Downstream download handshake: the buffer offers {addr, data} with
// ioctl_wr, and the SDRAM writer takes it by raising ioctl_rdy.
interface jtframe_mister_dlbuf_if #(
  parameter int DW = 8
);

  logic                                ioctl_wr;
  logic                                ioctl_rdy;
  logic [jtframe_mister_pkg::ADDR_W-1:0] ioctl_addr;
  logic [DW-1:0]                       ioctl_dout;

  modport master (
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  ioctl_rdy
  );

  modport slave (
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output ioctl_rdy
  );

endinterface

// File: rtl/jtframe_mister_fifo.sv
// Generic synchronous FIFO with a separate occupancy counter so that a full
// buffer is distinguishable from an empty one. Push at full is taken only
// when a pop happens in the same cycle.
module jtframe_mister_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // NOTE: every signal driven here is given a value on every path, so no latch is inferred.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jtframe_mister_dlbuf.sv
// MiSTer HPS download front end: latches the menu index, routes ROM/NVRAM
// writes through a FIFO, captures core mode and DIP bytes. The macro
// JTFRAME_MRA_DIP_EN enables DIP capture from index 254.
module jtframe_mister_dlbuf
  import jtframe_mister_pkg::*;
#(
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int AFULL    = DEPTH - 2,
  parameter int DIPBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hps_download,
  input  logic [7:0]             hps_index,
  input  logic                   hps_wr,
  input  logic [ADDR_W-1:0]      hps_addr,
  input  logic [DW-1:0]          hps_dout,
  output logic                   hps_wait,
  output logic                   downloading,
  output logic                   ioctl_ram,
  jtframe_mister_dlbuf_if.master ioctl,
  output logic [6:0]             core_mod,
  input  logic [31:0]            status,
  output logic [8*DIPBYTES-1:0]  dipsw,
  output logic                   ovf
);

  localparam int AW   = $clog2(DEPTH);
  localparam int DIPW = 8 * DIPBYTES;
  localparam int FW   = ADDR_W + DW;

  logic        dl_prev_q, dl_prev_d;
  logic [7:0]  idx_q, idx_d;
  logic        downloading_q, downloading_d;
  logic        ioctl_ram_q, ioctl_ram_d;
  logic        hps_wait_q, hps_wait_d;
  logic        ovf_q, ovf_d;
  logic [6:0]  core_mod_q, core_mod_d;

  logic        rise;
  logic [7:0]  idx_eff;
  dl_kind_e    kind;
  logic        wr_en, push_req, pop, drop, push_ok;
  logic [AW:0] cnt_nxt;

  logic [FW-1:0] head;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty;

  jtframe_mister_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   ({hps_addr, hps_dout}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ioctl.ioctl_wr   = !fifo_empty;
  assign ioctl.ioctl_addr = head[FW-1:DW];
  assign ioctl.ioctl_dout = head[DW-1:0];

  always_comb begin
    rise     = hps_download && !dl_prev_q;
    // The index is taken straight from the bus on the rising edge so writes
    // in that same cycle are already routed correctly.
    idx_eff  = rise ? hps_index : idx_q;
    kind     = dl_kind(idx_eff);
    wr_en    = hps_download && hps_wr;
    push_req = wr_en && (kind == DL_ROM || kind == DL_NVRAM);
    pop      = !fifo_empty && ioctl.ioctl_rdy;
    drop     = push_req && fifo_full && !pop;
    push_ok  = push_req && !drop;
    cnt_nxt  = fifo_count + (AW+1)'(push_ok) - (AW+1)'(pop);

    dl_prev_d     = hps_download;
    idx_d         = idx_eff;
    downloading_d = (hps_download && kind == DL_ROM) ||
                    (downloading_q && (hps_download || !fifo_empty));
    ioctl_ram_d   = (hps_download && kind == DL_NVRAM) ||
                    (ioctl_ram_q && (hps_download || !fifo_empty));
    // Looking at next occupancy leaves two spare slots for in-flight writes.
    hps_wait_d    = int'(cnt_nxt) >= AFULL;
    ovf_d         = (rise ? 1'b0 : ovf_q) | drop;

    core_mod_d = core_mod_q;
    if (wr_en && kind == DL_MOD && (DW == 16 || !hps_addr[0]))
      core_mod_d = hps_dout[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_prev_q     <= 1'b0;
      idx_q         <= IDX_ROM;
      downloading_q <= 1'b0;
      ioctl_ram_q   <= 1'b0;
      hps_wait_q    <= 1'b0;
      ovf_q         <= 1'b0;
      core_mod_q    <= CORE_MOD_RST;
    end else begin
      dl_prev_q     <= dl_prev_d;
      idx_q         <= idx_d;
      downloading_q <= downloading_d;
      ioctl_ram_q   <= ioctl_ram_d;
      hps_wait_q    <= hps_wait_d;
      ovf_q         <= ovf_d;
      core_mod_q    <= core_mod_d;
    end
  end

  assign hps_wait    = hps_wait_q;
  assign downloading = downloading_q;
  assign ioctl_ram   = ioctl_ram_q;
  assign ovf         = ovf_q;
  assign core_mod    = core_mod_q;

`ifdef JTFRAME_MRA_DIP_EN
  logic [DIPW-1:0] dip_q, dip_d;
  logic [15:0]     dout16;

  always_comb begin
    dout16 = 16'(hps_dout);
    dip_d  = dip_q;
    if (wr_en && kind == DL_DIPSW) begin
      for (int k = 0; k < DIPBYTES; k++) begin
        if ({1'b0, hps_addr} == 28'(k))
          dip_d[8*k +: 8] = dout16[7:0];
        // A 16-bit word also carries byte addr+1; it falls off past the end.
        if (DW == 16 && ({1'b0, hps_addr} + 28'd1) == 28'(k))
          dip_d[8*k +: 8] = dout16[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dip_q <= '1;
    else        dip_q <= dip_d;
  end

  assign dipsw = dip_q;
`else
  assign dipsw = DIPW'(status);
`endif

endmodule

// File: tb/tb_jtframe_mister_dlbuf.sv
// Self-checking bench for jtframe_mister_dlbuf (16-bit bus, 8-entry FIFO,
// 3 DIP bytes): directed scenarios plus random downloads against a queue model.
`timescale 1ns/1ps
module tb_jtframe_mister_dlbuf;

  localparam int DW       = 16;
  localparam int DEPTH    = 8;
  localparam int AFULL    = DEPTH - 2;
  localparam int DIPBYTES = 3;

  typedef struct packed {
    logic [26:0]   addr;
    logic [DW-1:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hps_download = 1'b0;
  logic [7:0]  hps_index = 8'd0;
  logic        hps_wr = 1'b0;
  logic [26:0] hps_addr = '0;
  logic [DW-1:0] hps_dout = '0;
  logic [31:0] status = 32'hDEADBEEF;
  logic        rdy = 1'b0;
  logic        tog = 1'b0;
  logic        hps_wait, downloading, ioctl_ram, ovf;
  logic [6:0]  core_mod;
  logic [8*DIPBYTES-1:0] dipsw;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  jtframe_mister_dlbuf_if #(.DW(DW)) ioctl_if ();
  assign ioctl_if.ioctl_rdy = rdy;

  jtframe_mister_dlbuf #(
    .DW(DW), .DEPTH(DEPTH), .AFULL(AFULL), .DIPBYTES(DIPBYTES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hps_download (hps_download),
    .hps_index    (hps_index),
    .hps_wr       (hps_wr),
    .hps_addr     (hps_addr),
    .hps_dout     (hps_dout),
    .hps_wait     (hps_wait),
    .downloading  (downloading),
    .ioctl_ram    (ioctl_ram),
    .ioctl        (ioctl_if),
    .core_mod     (core_mod),
    .status       (status),
    .dipsw        (dipsw),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ent_t        m_q[$];
  ent_t        obs_q[$];
  logic        m_dl_prev, m_downloading, m_ram, m_wait, m_ovf;
  logic [7:0]  m_idx;
  logic [6:0]  m_core;
  logic [23:0] m_dip;
  bit          r, p, req, drop, emp;
  logic [7:0]  ix;
  ent_t        e;
  int          a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_dl_prev = 0; m_downloading = 0; m_ram = 0; m_wait = 0; m_ovf = 0;
      m_idx = 8'd0; m_core = 7'h01; m_dip = 24'hFFFFFF;
    end else begin
      if (ioctl_if.ioctl_wr && rdy) begin
        e = {ioctl_if.ioctl_addr, ioctl_if.ioctl_dout};
        obs_q.push_back(e);
      end
      r    = hps_download && !m_dl_prev;
      ix   = r ? hps_index : m_idx;
      emp  = (m_q.size() == 0);
      p    = !emp && rdy;
      req  = hps_download && hps_wr && (ix == 8'd0 || ix == 8'd2);
      drop = req && m_q.size() >= DEPTH && !p;
      if (p) void'(m_q.pop_front());
      if (req && !drop) begin
        e = {hps_addr, hps_dout};
        m_q.push_back(e);
      end
      m_ovf         = (r ? 1'b0 : m_ovf) | drop;
      m_downloading = (hps_download && ix == 8'd0) || (m_downloading && (hps_download || !emp));
      m_ram         = (hps_download && ix == 8'd2) || (m_ram && (hps_download || !emp));
      m_wait        = m_q.size() >= AFULL;
      if (hps_download && hps_wr && ix == 8'd1) m_core = hps_dout[6:0];
      if (hps_download && hps_wr && ix == 8'd254) begin
        a = int'(hps_addr);
        if (a < DIPBYTES)     m_dip[8*a +: 8]     = hps_dout[7:0];
        if (a + 1 < DIPBYTES) m_dip[8*(a+1) +: 8] = hps_dout[15:8];
      end
      m_idx     = ix;
      m_dl_prev = hps_download;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ioctl_wr", ioctl_if.ioctl_wr, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("head_addr", ioctl_if.ioctl_addr, m_q[0].addr);
        check("head_data", ioctl_if.ioctl_dout, m_q[0].data);
      end
      check("hps_wait", hps_wait, m_wait);
      check("downloading", downloading, m_downloading);
      check("ioctl_ram", ioctl_ram, m_ram);
      check("ovf", ovf, m_ovf);
      check("core_mod", core_mod, m_core);
`ifdef JTFRAME_MRA_DIP_EN
      check("dipsw", dipsw, m_dip);
`else
      check("dipsw", dipsw, status[23:0]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) rdy = !rdy;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    hps_index = idx; hps_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    hps_download = 1'b0; hps_wr = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [26:0] ad, input logic [DW-1:0] d);
    hps_wr = 1'b1; hps_addr = ad; hps_dout = d;
    tick();
    hps_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((ioctl_if.ioctl_wr || downloading || ioctl_ram) && n < 300) begin
      tick(); n++;
    end
    check("drain_done", {ioctl_if.ioctl_wr, downloading, ioctl_ram}, 3'b000);
  endtask

  function automatic logic [7:0] pick_idx();
    logic [7:0] tab [5] = '{8'd0, 8'd1, 8'd2, 8'd254, 8'd9};
    return tab[$urandom_range(0, 4)];
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check("rst_core_mod", core_mod, 7'h01);
    check("rst_ioctl_wr", ioctl_if.ioctl_wr, 1'b0);
`ifdef JTFRAME_MRA_DIP_EN
    check("rst_dipsw", dipsw, 24'hFFFFFF);
`endif

    // Basic ROM path
    rdy = 1'b1; obs_q.delete();
    start_dl(8'd0);
    check("rom_dl_rise", downloading, 1'b1);
    for (int i = 0; i < 16; i++) begin
      wr(27'(2*i), DW'(16'h00A0 + i));
      if (i == 0) check("rom_latency", {ioctl_if.ioctl_wr, ioctl_if.ioctl_addr}, {1'b1, 27'd0});
    end
    end_dl();
    check("rom_dl_hold", downloading, 1'b1);
    tick();
    check("rom_dl_fall", downloading, 1'b0);
    drain();
    check("rom_count", obs_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++)
      check("rom_order", {obs_q[i].addr, obs_q[i].data}, {27'(2*i), DW'(16'h00A0 + i)});

    // Back-pressure and overflow
    rdy = 1'b0; obs_q.delete();
    start_dl(8'd0);
    for (int i = 0; i < 10; i++) begin
      wr(27'(2*i), DW'(16'h0100 + i));
      if (i == 4) check("bp_wait_low", hps_wait, 1'b0);
      if (i == 5) check("bp_wait_high", hps_wait, 1'b1);
    end
    check("bp_ovf", ovf, 1'b1);
    check("bp_head", ioctl_if.ioctl_dout, 16'h0100);
    rdy = 1'b1;
    end_dl();
    drain();
    check("bp_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check("bp_order", obs_q[i].data, 16'h0100 + i);
    start_dl(8'd9);
    check("ovf_clear", ovf, 1'b0);
    end_dl();

    // NVRAM with a stalling writer
    rdy = 1'b0; tog = 1'b1; obs_q.delete();
    start_dl(8'd2);
    wr(27'd0, 16'h1234);
    check("nv_ram", ioctl_ram, 1'b1);
    wr(27'd2, 16'h5678);
    wr(27'd4, 16'h9ABC);
    end_dl();
    drain();
    tog = 1'b0; rdy = 1'b1;
    check("nv_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("nv_d0", obs_q[0].data, 16'h1234);
      check("nv_d1", obs_q[1].data, 16'h5678);
      check("nv_d2", {obs_q[2].addr, obs_q[2].data}, {27'd4, 16'h9ABC});
    end

    // Core mode: a 16-bit bus loads on every write
    start_dl(8'd1);
    wr(27'd0, 16'h0005);
    check("mod_05", core_mod, 7'h05);
    wr(27'd2, 16'h00FF);
    check("mod_7f", core_mod, 7'h7F);
    check("mod_no_fifo", ioctl_if.ioctl_wr, 1'b0);
    end_dl();

    // DIP capture; the high byte at addr 2 lands past the last DIP byte
    start_dl(8'd254);
    wr(27'd0, 16'h2211);
    wr(27'd2, 16'h4433);
    end_dl();
`ifdef JTFRAME_MRA_DIP_EN
    check("dip_capture", dipsw, 24'h332211);
`else
    check("dip_status", dipsw, 24'hADBEEF);
`endif

    // Reset in the middle of a ROM download
    rdy = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 5; i++) wr(27'(i), DW'(i));
    check("rst_pre_wr", ioctl_if.ioctl_wr, 1'b1);
    rst_n = 1'b0; hps_download = 1'b0;
    #2;
    check("rst_mid_wr", ioctl_if.ioctl_wr, 1'b0);
    check("rst_mid_dl", downloading, 1'b0);
    check("rst_mid_mod", core_mod, 7'h01);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Random downloads, with index noise mid-download and occasional wait violations
    for (int d = 0; d < 40; d++) begin
      start_dl(pick_idx());
      for (int c = $urandom_range(5, 40); c > 0; c--) begin
        hps_index = pick_idx();
        hps_addr  = ($urandom_range(0, 1) == 1) ? 27'($urandom_range(0, 4)) : 27'($urandom);
        hps_dout  = DW'($urandom);
        hps_wr    = ($urandom_range(0, 3) != 0) && (!hps_wait || $urandom_range(0, 4) == 0);
        rdy       = ($urandom_range(0, 9) < 6);
        tick();
      end
      end_dl();
      for (int c = $urandom_range(0, 12); c > 0; c--) begin
        rdy = ($urandom_range(0, 9) < 6);
        tick();
      end
    end
    rdy = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
